// File: rtl/spike_net_pkg.sv
// Shared definitions for the spike network arbitration blocks: FSM state
// encoding, id-width helper and a saturating adder for event counters.
package spike_net_pkg;

   // Channel FSM states: waiting for work, driving a pulse, enforcing the gap.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FIRE = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   // Width of a neuron index; never narrower than one bit.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Add inc to v, clamping the result at max.
   function automatic logic [63:0] sat_add(input logic [63:0] v,
                                           input logic [63:0] inc,
                                           input logic [63:0] max);
      logic [63:0] sum;
      sum = v + inc;
      if (sum > max || sum < v) begin
         return max;
      end
      return sum;
   endfunction

endpackage

// File: rtl/spike_rr_picker.sv
// Combinational round-robin search: returns the first set pending bit found
// when scanning upward from pointer+1, wrapping around past index N-1.
module spike_rr_picker #(
   parameter int N    = 2,
   parameter int ID_W = 1
) (
   input  logic [N-1:0]    pending,
   input  logic [ID_W-1:0] pointer,
   output logic            valid,
   output logic [ID_W-1:0] winner
);

   logic [ID_W:0] base;
   logic [N-1:0]  rot;
   int            wsum;

   // Rotate pending so bit 0 is the highest-priority source, then take the
   // lowest set bit and map its offset back to an absolute index.
   always_comb begin
      base   = {1'b0, pointer} + {{ID_W{1'b0}}, 1'b1};
      rot    = N'({pending, pending} >> base);
      valid  = 1'b0;
      wsum   = 0;
      winner = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (rot[j]) begin
            valid = 1'b1;
            wsum  = int'(base) + j;
         end
      end
      if (wsum >= N) begin
         wsum = wsum - N;
      end
      winner = ID_W'(wsum);
   end

endmodule

// File: rtl/spike_channel_arbiter.sv
// Shares one synapse channel between N_NEURONS spike sources. Rising edges
// are latched into per-source pending bits, granted round-robin, and each
// grant produces a PULSE_LEN-cycle pulse tagged with the source id followed
// by GAP_LEN forced-idle cycles. Lost events are counted in drop_count.
module spike_channel_arbiter
   import spike_net_pkg::*;
#(
   parameter int N_NEURONS = 2,
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 2,
   parameter int CNT_W     = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [N_NEURONS-1:0]         spike_in,
   output logic                         spike_out,
   output logic [id_w(N_NEURONS)-1:0]   spike_id,
   output logic                         busy,
   output logic [N_NEURONS-1:0]         pending,
   output logic [CNT_W-1:0]             drop_count,
   output logic [1:0]                   state_dbg
);

   localparam int ID_W    = id_w(N_NEURONS);
   localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
   localparam int TW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [1:0]    S_IDLE     = ST_IDLE;
   localparam logic [1:0]    S_FIRE     = ST_FIRE;
   localparam logic [1:0]    S_GAP      = ST_GAP;
   localparam logic [TW-1:0] PULSE_INIT = TW'(PULSE_LEN - 1);
   localparam logic [TW-1:0] GAP_INIT   = TW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
   localparam logic [63:0]   DROP_MAX   = (64'd1 << CNT_W) - 64'd1;

   logic [1:0]           state_q, state_d;
   logic [TW-1:0]        tmr_q, tmr_d;
   logic [N_NEURONS-1:0] prev_q, prev_d;
   logic [N_NEURONS-1:0] pending_q, pending_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic                 spike_out_q, spike_out_d;
   logic [ID_W-1:0]      spike_id_q, spike_id_d;
   logic                 busy_q, busy_d;
   logic [CNT_W-1:0]     drop_q, drop_d;

   logic [N_NEURONS-1:0] events;
   logic [N_NEURONS-1:0] grant_mask;
   logic [N_NEURONS-1:0] drops;
   logic [31:0]          n_drops;
   logic                 pick_valid;
   logic [ID_W-1:0]      pick_idx;
   logic                 slot_free;
   logic                 grant;

   spike_rr_picker #(
      .N    (N_NEURONS),
      .ID_W (ID_W)
   ) u_picker (
      .pending (pending_q),
      .pointer (ptr_q),
      .valid   (pick_valid),
      .winner  (pick_idx)
   );

   // Rising-edge detection; history tracks spike_in even while disabled so
   // a level held across enable going high is not mistaken for a new event.
   always_comb begin
      prev_d = spike_in;
      events = spike_in & ~prev_q & {N_NEURONS{enable}};
   end

   // A new grant may start in IDLE or on the final cycle of the gap (or of
   // the pulse when there is no gap), keeping pulses exactly GAP_LEN apart.
   always_comb begin
      slot_free = 1'b0;
      case (state_q)
         S_IDLE:  slot_free = 1'b1;
         S_FIRE:  slot_free = (tmr_q == '0) && (GAP_LEN == 0);
         S_GAP:   slot_free = (tmr_q == '0);
         default: slot_free = 1'b1;
      endcase
      grant      = slot_free && enable && pick_valid;
      grant_mask = '0;
      if (grant) begin
         grant_mask[pick_idx] = 1'b1;
      end
   end

   // Channel FSM: pulse timing, gap timing and grant bookkeeping.
   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      spike_out_d = spike_out_q;
      spike_id_d  = spike_id_q;
      ptr_d       = ptr_q;
      case (state_q)
         S_FIRE: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - 1'b1;
            end else if (GAP_LEN > 0) begin
               state_d     = S_GAP;
               tmr_d       = GAP_INIT;
               spike_out_d = 1'b0;
            end else begin
               state_d     = S_IDLE;
               spike_out_d = 1'b0;
            end
         end
         S_GAP: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            spike_out_d = 1'b0;
         end
         default: begin
            state_d     = S_IDLE;
            spike_out_d = 1'b0;
         end
      endcase
      if (grant) begin
         state_d     = S_FIRE;
         tmr_d       = PULSE_INIT;
         spike_out_d = 1'b1;
         spike_id_d  = pick_idx;
         ptr_d       = pick_idx;
      end
      busy_d = (state_d != S_IDLE);
   end

   // Pending capture: a new event beats a same-cycle grant clear, and an
   // event hitting an already-pending bit that is not being granted is lost.
   always_comb begin
      pending_d = (pending_q & ~grant_mask) | events;
      drops     = events & pending_q & ~grant_mask;
      n_drops   = '0;
      for (int i = 0; i < N_NEURONS; i++) begin
         n_drops = n_drops + {31'd0, drops[i]};
      end
      drop_d = CNT_W'(sat_add(64'(drop_q), 64'(n_drops), DROP_MAX));
   end

   // State registers; reset aborts any pulse in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         tmr_q       <= '0;
         prev_q      <= '0;
         pending_q   <= '0;
         ptr_q       <= ID_W'(N_NEURONS - 1);
         spike_out_q <= 1'b0;
         spike_id_q  <= '0;
         busy_q      <= 1'b0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         prev_q      <= prev_d;
         pending_q   <= pending_d;
         ptr_q       <= ptr_d;
         spike_out_q <= spike_out_d;
         spike_id_q  <= spike_id_d;
         busy_q      <= busy_d;
         drop_q      <= drop_d;
      end
   end

   assign spike_out  = spike_out_q;
   assign spike_id   = spike_id_q;
   assign busy       = busy_q;
   assign pending    = pending_q;
   assign drop_count = drop_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_spike_channel_arbiter.sv
// Self-checking bench for spike_channel_arbiter: directed vector tables for
// the documented timing cases, a saturation sequence, then random stimulus
// compared every cycle against a window-position reference model.
module tb_spike_channel_arbiter;

   localparam int N    = 2;
   localparam int PL   = 4;
   localparam int GL   = 2;
   localparam int CW   = 3;
   localparam int IDW  = 1;
   localparam int W    = PL + GL;
   localparam int DMAX = (1 << CW) - 1;

   logic           clk = 1'b0;
   logic           reset;
   logic           enable;
   logic [N-1:0]   spike_in;
   logic           spike_out;
   logic [IDW-1:0] spike_id;
   logic           busy;
   logic [N-1:0]   pending;
   logic [CW-1:0]  drop_count;
   logic [1:0]     state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   logic [IDW-1:0] exp_q[$];
   logic           last_out = 1'b0;

   typedef struct {
      logic           rst;
      logic           en;
      logic [N-1:0]   sin;
      logic           out;
      logic [IDW-1:0] id;
      logic           busy;
      logic [N-1:0]   pend;
      logic [CW-1:0]  drops;
   } vec_t;

   vec_t tbl[$];

   // reference model: window position since the last grant
   logic [N-1:0] m_pend;
   logic [N-1:0] m_prev;
   int           m_last;
   int           m_pos;
   int           m_owner;
   int           m_drops;
   bit           m_inwin;

   spike_channel_arbiter #(
      .N_NEURONS (N),
      .PULSE_LEN (PL),
      .GAP_LEN   (GL),
      .CNT_W     (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .spike_in   (spike_in),
      .spike_out  (spike_out),
      .spike_id   (spike_id),
      .busy       (busy),
      .pending    (pending),
      .drop_count (drop_count),
      .state_dbg  (state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic en, input logic [N-1:0] sin);
      logic [N-1:0] ev;
      logic [N-1:0] gmask;
      int           idx;
      int           win;
      if (r) begin
         m_pend  = '0;
         m_prev  = '0;
         m_last  = N - 1;
         m_pos   = 0;
         m_owner = 0;
         m_drops = 0;
         m_inwin = 0;
      end else begin
         ev    = sin & ~m_prev & {N{en}};
         gmask = '0;
         win   = 0;
         if (m_inwin && m_pos < W - 1) begin
            m_pos++;
         end else begin
            m_inwin = 0;
            if (en && m_pend != '0) begin
               for (int k = 1; k <= N; k++) begin
                  idx = (m_last + k) % N;
                  if (m_pend[idx] && !m_inwin) begin
                     m_inwin = 1;
                     win     = idx;
                  end
               end
               m_pos       = 0;
               m_owner     = win;
               m_last      = win;
               gmask[win]  = 1'b1;
               exp_q.push_back(IDW'(win));
            end
         end
         for (int i = 0; i < N; i++) begin
            if (ev[i] && m_pend[i] && !gmask[i] && m_drops < DMAX) begin
               m_drops++;
            end
         end
         m_pend = (m_pend & ~gmask) | ev;
         m_prev = sin;
      end
   endtask

   task automatic compare_model(input int idx);
      logic       e_out;
      logic [1:0] e_state;
      e_out   = m_inwin && (m_pos < PL);
      e_state = !m_inwin ? 2'd0 : ((m_pos < PL) ? 2'd1 : 2'd2);
      check("m_out", idx, 32'(spike_out), 32'(e_out));
      check("m_id", idx, 32'(spike_id), 32'(m_owner));
      check("m_busy", idx, 32'(busy), 32'(m_inwin));
      check("m_pend", idx, 32'(pending), 32'(m_pend));
      check("m_drops", idx, 32'(drop_count), 32'(m_drops));
      check("m_state", idx, 32'(state_dbg), 32'(e_state));
      // scoreboard: every pulse start must match the next expected grant
      if (spike_out && !last_out) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_pulse[%0d]: got pulse id %0d expected no pulse", idx, spike_id);
         end else begin
            check("sb_id", idx, 32'(spike_id), 32'(exp_q.pop_front()));
         end
      end
      last_out = spike_out;
   endtask

   // driver: apply inputs, clock one edge, sample 1 time unit later
   task automatic step(input logic r, input logic en, input logic [N-1:0] sin, input int idx);
      reset    = r;
      enable   = en;
      spike_in = sin;
      @(posedge clk);
      model_edge(r, en, sin);
      #1;
      compare_model(idx);
   endtask

   function automatic void add(input logic r, input logic en, input logic [N-1:0] sin,
                               input logic out, input logic [IDW-1:0] id, input logic b,
                               input logic [N-1:0] pend, input logic [CW-1:0] drops,
                               input int reps);
      vec_t v;
      v.rst = r; v.en = en; v.sin = sin; v.out = out; v.id = id;
      v.busy = b; v.pend = pend; v.drops = drops;
      for (int i = 0; i < reps; i++) tbl.push_back(v);
   endfunction

   initial begin
      reset    = 1'b1;
      enable   = 1'b0;
      spike_in = '0;

      // reset, then 20 quiet cycles
      step(1'b1, 1'b0, 2'b00, 0);
      check("rst_out", 0, 32'(spike_out), 32'd0);
      check("rst_busy", 0, 32'(busy), 32'd0);
      check("rst_pend", 0, 32'(pending), 32'd0);
      check("rst_drops", 0, 32'(drop_count), 32'd0);
      for (int c = 0; c < 20; c++) begin
         step(1'b0, 1'b1, 2'b00, c);
         check("idle_busy", c, 32'(busy), 32'd0);
         check("idle_out", c, 32'(spike_out), 32'd0);
      end

      // single spike on source 0
      add(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1);
      add(0, 1, 2'b01, 0, 0, 0, 2'b01, 0, 1);
      add(0, 1, 2'b00, 1, 0, 1, 2'b00, 0, 4);
      add(0, 1, 2'b00, 0, 0, 1, 2'b00, 0, 2);
      add(0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 1);
      // both sources at once: id 0 then id 1, exactly GL low cycles apart
      add(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1);
      add(0, 1, 2'b11, 0, 0, 0, 2'b11, 0, 1);
      add(0, 1, 2'b11, 1, 0, 1, 2'b10, 0, 4);
      add(0, 1, 2'b11, 0, 0, 1, 2'b10, 0, 2);
      add(0, 1, 2'b11, 1, 1, 1, 2'b00, 0, 4);
      add(0, 1, 2'b00, 0, 1, 1, 2'b00, 0, 2);
      add(0, 1, 2'b00, 0, 1, 0, 2'b00, 0, 1);
      // repeated rises on source 0: re-capture, then one drop
      add(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1);
      add(0, 1, 2'b01, 0, 0, 0, 2'b01, 0, 1);
      add(0, 1, 2'b00, 1, 0, 1, 2'b00, 0, 1);
      add(0, 1, 2'b01, 1, 0, 1, 2'b01, 0, 1);
      add(0, 1, 2'b00, 1, 0, 1, 2'b01, 0, 1);
      add(0, 1, 2'b01, 1, 0, 1, 2'b01, 1, 1);
      add(0, 1, 2'b00, 0, 0, 1, 2'b01, 1, 2);
      add(0, 1, 2'b00, 1, 0, 1, 2'b00, 1, 4);
      add(0, 1, 2'b00, 0, 0, 1, 2'b00, 1, 2);
      add(0, 1, 2'b00, 0, 0, 0, 2'b00, 1, 1);
      // enable low blocks capture; a fresh rise with enable high is granted
      add(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1);
      add(0, 0, 2'b10, 0, 0, 0, 2'b00, 0, 3);
      add(0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 1);
      add(0, 1, 2'b10, 0, 0, 0, 2'b10, 0, 1);
      add(0, 1, 2'b00, 1, 1, 1, 2'b00, 0, 1);
      // reset in the middle of a pulse with source 1 pending
      add(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1);
      add(0, 1, 2'b01, 0, 0, 0, 2'b01, 0, 1);
      add(0, 1, 2'b11, 1, 0, 1, 2'b10, 0, 2);
      add(1, 1, 2'b00, 0, 0, 0, 2'b00, 0, 1);
      add(0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 8);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].en, tbl[i].sin, 100 + i);
         check("tbl_out", i, 32'(spike_out), 32'(tbl[i].out));
         check("tbl_id", i, 32'(spike_id), 32'(tbl[i].id));
         check("tbl_busy", i, 32'(busy), 32'(tbl[i].busy));
         check("tbl_pend", i, 32'(pending), 32'(tbl[i].pend));
         check("tbl_drops", i, 32'(drop_count), 32'(tbl[i].drops));
      end

      // drop counter saturation under constant toggling of both sources
      step(1'b1, 1'b0, 2'b00, 300);
      for (int c = 0; c < 40; c++) begin
         step(1'b0, 1'b1, (c % 2 == 0) ? 2'b11 : 2'b00, 301 + c);
      end
      check("sat_drops", 0, 32'(drop_count), 32'(DMAX));

      // randomized traffic against the reference model
      step(1'b1, 1'b0, 2'b00, 400);
      for (int c = 0; c < 1500; c++) begin
         step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
              N'($urandom_range(0, (1 << N) - 1)), 1000 + c);
      end

      check("sb_drain", 0, 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
